// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO with occupancy flags and sticky error flags.
//
// Storage is a DEPTH-entry register array. Read and write pointers wrap
// modulo DEPTH, and a separate occupancy counter produces every status flag.
// A request is accepted only when the flags at the start of the cycle allow
// it. A request that is rejected sets a sticky error flag instead.
//
// Configuration macro:
//   SYNC_FIFO_FWFT_EN - when defined, the FIFO runs in first-word-fall-through
//                       mode. o_data shows the head word combinationally and
//                       o_valid is !empty. When undefined (the default), a
//                       read registers the head word into o_data with
//                       1-cycle latency, and o_valid pulses for that cycle.
//
// Parameters:
//   DEPTH       entry count (power of two, >= 2)
//   DATA_WIDTH  word width in bits
//   AF_THRESH   almost_full when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH   almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         asynchronous active-low reset
//   wren, i_data  write request and write data
//   rden          read request
//   clr_err       synchronous clear of overflow/underflow
//   o_data        read data
//   o_valid       o_data holds a popped word (or the head word in FWFT mode)
//   full, empty, almost_full, almost_empty  occupancy status
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected because the FIFO was full
//   underflow     sticky: a read was rejected because the FIFO was empty
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wren,
   input  logic [DATA_WIDTH-1:0]       i_data,
   input  logic                        rden,
   input  logic                        clr_err,
   output logic [DATA_WIDTH-1:0]       o_data,
   output logic                        o_valid,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  wr_acc;
   logic                  rd_acc;

   // Acceptance uses the registered flags. At full, a simultaneous read is
   // still accepted and the write is rejected. At empty, the reverse happens.
   assign wr_acc = wren & ~full;
   assign rd_acc = rden & ~empty;

   // All status flags come from the count register, so they are glitch-free.
   assign count        = count_q;
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_THRESH));
   assign almost_empty = (count_q <= CW'(AE_THRESH));

   // Memory has no reset. Stale contents become unreachable because reset
   // returns both pointers and the count to zero.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // Pointers and count. DEPTH is a power of two, so the natural AW-bit
   // rollover of each pointer gives the modulo-DEPTH wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count_q <= count_q + CW'(wr_acc) - CW'(rd_acc);
      end
   end

   // Sticky error flags. A new error takes priority over clr_err, so an error
   // raised in the same cycle as the clear is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wren && full) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (rden && empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // FWFT: the head word is always visible. rden simply advances rd_ptr.
   assign o_data  = mem[rd_ptr];
   assign o_valid = ~empty;
`else
   // Standard mode: the popped word is registered, so there is no
   // combinational path from memory to o_data. o_valid pulses for one cycle
   // per accepted read, and o_data holds its value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data  <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= rd_acc;
         if (rd_acc) begin
            o_data <= mem[rd_ptr];
         end
      end
   end
`endif

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DEPTH, default 8: entry count; power of two, >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: word width in bits.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full asserts at count >= AF_THRESH; legal range 1..DEPTH.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty asserts at count <= AE_THRESH; legal range 0..DEPTH-1.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port wren  input  1  write request.
REQ-008 SHALL have port i_data  input  DATA_WIDTH  write data.
REQ-009 SHALL have port rden  input  1  read request.
REQ-010 SHALL have port clr_err  input  1  synchronous clear of the overflow and underflow flags.
REQ-011 SHALL have port o_data  output  DATA_WIDTH  read data.
REQ-012 SHALL have port o_valid  output  1  o_data holds a popped word, or the head word in FWFT mode.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  occupancy status.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 A write SHALL be accepted iff wren=1 and full=0; i_data is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-017 A read SHALL be accepted iff rden=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-018 Acceptance SHALL use the flag values at the start of the cycle. Simultaneous accepted read and write leave count unchanged.
REQ-019 count SHALL update as count + accepted_write - accepted_read each cycle, and SHALL never exceed DEPTH or go below 0.
REQ-020 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both derived from the count register.
REQ-021 almost_full SHALL equal (count>=AF_THRESH) and almost_empty SHALL equal (count<=AE_THRESH).
REQ-022 At full, wren=1 with rden=1 SHALL accept only the read; the write is rejected and overflow is set.
REQ-023 At empty, wren=1 with rden=1 SHALL accept only the write; the read is rejected and underflow is set.
REQ-024 overflow SHALL set on the cycle after any rejected write and SHALL hold until clr_err=1 or reset.
REQ-025 underflow SHALL set on the cycle after any rejected read and SHALL hold until clr_err=1 or reset.
REQ-026 If a set condition and clr_err=1 occur in the same cycle, set SHALL win.
REQ-027 In standard mode, an accepted read SHALL load mem[rd_ptr] into o_data at the next edge, giving 1-cycle latency. o_valid SHALL pulse high for that one cycle, and o_data SHALL hold its value otherwise.
REQ-028 Pointer wrap-around SHALL be transparent: data order is preserved across any number of wraps.

Reset
REQ-029 When rst_n=0, SHALL asynchronously set wr_ptr=0, rd_ptr=0, count=0, o_data=0, o_valid=0, overflow=0 and underflow=0.
REQ-030 While in reset, outputs SHALL be empty=1, full=0, almost_empty=1, and almost_full=0 (for AF_THRESH>=1).
REQ-031 Reset SHALL NOT be required to clear memory contents.
REQ-032 Reset asserted mid-transfer SHALL discard all stored words. The first accepted write after reset lands in entry 0.

Configuration
REQ-033 With macro SYNC_FIFO_FWFT_EN defined, the block SHALL operate first-word-fall-through: o_data = mem[rd_ptr] combinationally, o_valid = !empty, and rden pops the head.
REQ-034 In FWFT mode, a word written into an empty FIFO SHALL appear on o_data and o_valid the cycle after its write edge.
REQ-035 Without SYNC_FIFO_FWFT_EN, the block SHALL operate per REQ-027, and no combinational path from memory to o_data SHALL exist.

Verification (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=2, standard mode unless noted)
REQ-036 Write 0x01..0x08, then read 8 words -> full=1 after the 8th write, o_data sequence 0x01..0x08 each with a 1-cycle o_valid pulse, empty=1 at end.
REQ-037 Fill to 8, then wren=1 with i_data=0xAA -> write rejected, count stays 8, overflow=1. Pulse clr_err -> overflow=0.
REQ-038 rden=1 while empty -> underflow=1, o_valid=0, count=0. Same cycle with wren=1 (0x55) -> count=1, underflow=1.
REQ-039 Write 6 words -> almost_full rises on the 6th accepted write, almost_empty falls on the 3rd. Read 4 -> almost_empty=1 at count=2.
REQ-040 Stream 20 words with wren=rden=1 every cycle after the first write -> count holds at 1 and all words arrive in order through pointer wrap.
REQ-041 Write 3 words, assert rst_n=0 mid-cycle -> immediate empty=1, count=0, o_valid=0. Define SYNC_FIFO_FWFT_EN, write 0x3C -> o_data=0x3C, o_valid=1 the next cycle without rden.
